gray_seq_checker: RTL and testbench
===================================

Name: gray_seq_checker

Overview:
- Consumer stage placed directly downstream of the 4-bit Gray counter.
- Samples the counter's Gray output whenever it is qualified valid and converts each sample to binary.
- Checks that consecutive samples follow the Gray sequence: +1 step with modulo-2^WIDTH wrap, or a hold.
- Reports lock status, step errors, wrap events and a saturating error count for debug and self-test.

Parameters:
- WIDTH, 4: Gray/binary code width in bits.
- LOCK_CNT, 2: consecutive correct +1 steps needed to reach LOCKED (range 1..15).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- gray_valid  in  1  gray_in is sampled this cycle; driven from the upstream counter's clock enable.
- gray_in  in  WIDTH  Gray code from the upstream counter.
- bin_out  out  WIDTH  registered binary equivalent of the last valid sample.
- bin_valid  out  1  one-cycle pulse: bin_out was updated this cycle.
- locked  out  1  high while the FSM is in LOCKED.
- step_err  out  1  one-cycle pulse on a detected sequence violation.
- wrap  out  1  one-cycle pulse on a correct step from all-ones binary to zero.
- err_count  out  ERR_W  number of step errors, saturating at all-ones.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0.
  - FSM enters EMPTY; the reference register and step counter clear.
  - Reset mid-sequence discards all history; the first valid sample after release is treated as a fresh reference, with no error.
- Conversion (combinational from gray_in):
  - b[WIDTH-1] = g[WIDTH-1].
  - b[i] = b[i+1] XOR g[i].
- Registering: on every cycle with gray_valid=1:
  - bin_out <= converted value and bin_valid=1 in the next cycle (latency 1).
  - The reference register (ref) <= converted value.
  - bin_valid is 0 on cycles following gray_valid=0.
  - Outputs are unchanged when gray_valid=0.
- Sample classification (valid sample, converted value b, compared to ref):
  - HOLD: b == ref.
  - STEP: b == ref+1 modulo 2^WIDTH.
  - BAD: anything else.
- FSM:
  - EMPTY: the first valid sample loads ref, step counter cleared, go to ACQ. No classification and no error.
  - ACQ:
    - STEP: increment step counter; when it reaches LOCK_CNT, go to LOCKED and clear the counter.
    - HOLD: no change.
    - BAD: step counter cleared, stay in ACQ, step_err pulse, err_count increments.
  - LOCKED:
    - STEP or HOLD: stay.
    - BAD: step_err pulse, err_count increments, go to ACQ with step counter cleared.
  - The BAD sample always becomes the new ref (resync to the observed value).
- wrap: pulses on a STEP from ref = 2^WIDTH-1 to b = 0, in ACQ or LOCKED. Never pulses on the first sample or on a BAD sample.
- Timing of pulses and status:
  - step_err, wrap and bin_valid are registered and coincide with the bin_out update, one cycle after the sample.
  - locked changes on that same edge.
- err_count: increments by 1 per BAD sample. It holds at all-ones (255 for ERR_W=8) and never wraps. Only reset clears it.
- Simultaneous events:
  - gray_valid low on the cycle rst releases: stay in EMPTY.
  - A BAD sample that is numerically ref+2 or greater is an error even if it is a single-bit Gray change.

Test Plan:
- Reset release, then feed the full 16-code sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0 with gray_valid=1 each cycle:
  - bin_out = 0..15 then 0, each one cycle after its sample.
  - locked rises after the 3rd sample (2 steps).
  - wrap pulses exactly once, on the 8->0 sample.
  - step_err is never asserted.
- In LOCKED at gray 4 (bin 7), present gray 4 for 3 valid cycles then gray C: no error, stays locked, bin_out 7,7,7,8.
- In LOCKED at bin 5, inject gray F (bin 10):
  - step_err pulses once, err_count=1, locked drops.
  - Continuing E, A gives locked=1 again after the 2nd correct step.
- gray_valid toggling 1,0,1,0 along the legal sequence: bin_valid pulses only after valid cycles, no errors, lock still reached after 2 steps.
- Force 300 consecutive BAD samples (alternate gray 0 and gray F): err_count saturates at 255 and stays there.
- Assert rst low mid-sequence while LOCKED with err_count=3:
  - All outputs return to 0 immediately, without waiting for a clock edge.
  - After release, the first sample (gray 6) gives bin_out=4, no step_err, locked=0.

Source files
------------

// File: rtl/gray_seq_checker_if.sv
// gray_seq_checker_if: bundles the Gray sample input and the checker's status outputs
//   master: drives gray_valid/gray_in and observes results (upstream/testbench side)
//   slave : the checker; consumes samples and drives bin_out, bin_valid, locked,
//           step_err, wrap, err_count
interface gray_seq_checker_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic             gray_valid;
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             locked;
  logic             step_err;
  logic             wrap;
  logic [ERR_W-1:0] err_count;
  modport master (
    output gray_valid, gray_in,
    input  bin_out, bin_valid, locked, step_err, wrap, err_count
  );
  modport slave (
    input  gray_valid, gray_in,
    output bin_out, bin_valid, locked, step_err, wrap, err_count
  );
endinterface

// File: rtl/gray_seq_checker.sv
// gray_seq_checker: converts qualified Gray samples to binary and checks they advance by +1 (mod 2^WIDTH) or hold
//   clk            : system clock, rising edge
//   rst            : asynchronous active-low reset
//   bus.gray_valid : sample gray_in this cycle
//   bus.gray_in    : Gray code from upstream counter
//   bus.bin_out    : registered binary of last valid sample
//   bus.bin_valid  : pulse, bin_out updated
//   bus.locked     : FSM is in LOCKED
//   bus.step_err   : pulse, sequence violation
//   bus.wrap       : pulse, correct step from all-ones to zero
//   bus.err_count  : saturating count of step errors
module gray_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input logic              clk,
  input logic              rst,
  gray_seq_checker_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ACQ, LOCKED} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] bin_d, ref_inc_d, bin_q, ref_q;
  logic [3:0]       cnt_q, cnt_inc_d;
  logic [ERR_W-1:0] err_q;
  logic             bin_valid_q, step_err_q, wrap_q;
  logic             hold_d, step_d;
  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_d = '0;
    for (int i = 0; i < WIDTH; i++) bin_d[i] = ^(bus.gray_in >> i);
  end
  assign ref_inc_d = ref_q + WIDTH'(1);
  assign cnt_inc_d = cnt_q + 4'd1;
  assign hold_d    = bin_d == ref_q;
  assign step_d    = bin_d == ref_inc_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      bin_q       <= '0;
      ref_q       <= '0;
      cnt_q       <= '0;
      err_q       <= '0;
      bin_valid_q <= 1'b0;
      step_err_q  <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      bin_valid_q <= bus.gray_valid;
      step_err_q  <= 1'b0;
      wrap_q      <= 1'b0;
      if (bus.gray_valid) begin
        bin_q <= bin_d;
        // Every sample, including a bad one, becomes the new reference (resync).
        ref_q <= bin_d;
        if (state_q == EMPTY) begin
          state_q <= ACQ;
          cnt_q   <= '0;
        end else if (step_d) begin
          wrap_q <= ref_q == '1;
          if (state_q != LOCKED) begin
            state_q <= cnt_inc_d == 4'(LOCK_CNT) ? LOCKED : ACQ;
            cnt_q   <= cnt_inc_d == 4'(LOCK_CNT) ? 4'd0 : cnt_inc_d;
          end
        end else if (!hold_d) begin
          state_q    <= ACQ;
          cnt_q      <= '0;
          step_err_q <= 1'b1;
          err_q      <= err_q == '1 ? err_q : err_q + ERR_W'(1);
        end
      end
    end
  end
  assign bus.bin_out   = bin_q;
  assign bus.bin_valid = bin_valid_q;
  assign bus.locked    = state_q == LOCKED;
  assign bus.step_err  = step_err_q;
  assign bus.wrap      = wrap_q;
  assign bus.err_count = err_q;
endmodule

// File: tb/tb_gray_seq_checker.sv
// tb_gray_seq_checker: table vectors, directed corner sequences and random stimulus against a reference model
module tb_gray_seq_checker;
  localparam int LOCK = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  gray_seq_checker_if #(.WIDTH(4), .ERR_W(8)) bus ();
  gray_seq_checker #(.WIDTH(4), .LOCK_CNT(LOCK), .ERR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct {
    logic [3:0] gray;
    int         bin;
    bit         locked;
    bit         wrap;
  } vec_t;
  vec_t tbl[17];
  int   m_ref, m_streak, m_err, m_bin;
  bit   m_have, m_lock, m_bv, m_se, m_wr;
  function automatic int g2b(input int g);
    int b = g;
    for (int s = 1; s < 4; s++) b = b ^ (g >> s);
    return b;
  endfunction
  function automatic logic [3:0] b2g(input int b);
    return 4'((b ^ (b >> 1)) & 15);
  endfunction
  function automatic void model_reset();
    m_ref = 0; m_streak = 0; m_err = 0; m_bin = 0;
    m_have = 0; m_lock = 0; m_bv = 0; m_se = 0; m_wr = 0;
  endfunction
  function automatic void model_step(input bit v, input int g);
    int b;
    m_bv = v; m_se = 0; m_wr = 0;
    if (v) begin
      b = g2b(g);
      m_bin = b;
      if (!m_have) begin
        m_have = 1; m_streak = 0;
      end else if (b == (m_ref + 1) % 16) begin
        m_wr = (b == 0);
        if (!m_lock) begin
          m_streak++;
          if (m_streak >= LOCK) begin m_lock = 1; m_streak = 0; end
        end
      end else if (b != m_ref) begin
        m_se = 1; m_lock = 0; m_streak = 0;
        m_err = m_err < 255 ? m_err + 1 : 255;
      end
      m_ref = b;
    end
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic cmp_all();
    chk("bin_out", 32'(bus.bin_out), m_bin);
    chk("bin_valid", 32'(bus.bin_valid), 32'(m_bv));
    chk("locked", 32'(bus.locked), 32'(m_lock));
    chk("step_err", 32'(bus.step_err), 32'(m_se));
    chk("wrap", 32'(bus.wrap), 32'(m_wr));
    chk("err_count", 32'(bus.err_count), m_err);
  endtask
  task automatic cyc(input bit v, input logic [3:0] g);
    bus.gray_valid = v;
    bus.gray_in    = g;
    model_step(v, int'(g));
    @(posedge clk);
    #1;
    cmp_all();
  endtask
  task automatic do_reset();
    rst = 1'b0;
    bus.gray_valid = 1'b0;
    model_reset();
    #1;
    chk("rst_bin_out", 32'(bus.bin_out), 0);
    chk("rst_bin_valid", 32'(bus.bin_valid), 0);
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_step_err", 32'(bus.step_err), 0);
    chk("rst_wrap", 32'(bus.wrap), 0);
    chk("rst_err_count", 32'(bus.err_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b0, 4'hF);
  endtask
  initial begin
    logic [3:0] seq[17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                            4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    logic [3:0] g;
    bit v;
    int r;
    for (int k = 0; k < 17; k++) tbl[k] = '{gray: seq[k], bin: k % 16, locked: k >= 2, wrap: k == 16};
    bus.gray_valid = 1'b0;
    bus.gray_in    = 4'h0;
    #2;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      cyc(1'b1, tbl[k].gray);
      chk("tbl_bin", 32'(bus.bin_out), tbl[k].bin);
      chk("tbl_locked", 32'(bus.locked), 32'(tbl[k].locked));
      chk("tbl_wrap", 32'(bus.wrap), 32'(tbl[k].wrap));
      chk("tbl_step_err", 32'(bus.step_err), 0);
    end
    for (int k = 1; k <= 7; k++) cyc(1'b1, seq[k]);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 4'h4);
      chk("hold_bin", 32'(bus.bin_out), 7);
      chk("hold_locked", 32'(bus.locked), 1);
    end
    cyc(1'b1, 4'hC);
    chk("hold_then_step_bin", 32'(bus.bin_out), 8);
    chk("hold_err_count", 32'(bus.err_count), 0);
    for (int k = 9; k <= 16; k++) cyc(1'b1, seq[k]);
    for (int k = 1; k <= 5; k++) cyc(1'b1, seq[k]);
    chk("pre_bad_locked", 32'(bus.locked), 1);
    cyc(1'b1, 4'hF);
    chk("bad_step_err", 32'(bus.step_err), 1);
    chk("bad_err_count", 32'(bus.err_count), 1);
    chk("bad_locked", 32'(bus.locked), 0);
    cyc(1'b1, 4'hE);
    chk("relock_1step", 32'(bus.locked), 0);
    cyc(1'b1, 4'hA);
    chk("relock_2step", 32'(bus.locked), 1);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, seq[k]);
      chk("tog_bin_valid_hi", 32'(bus.bin_valid), 1);
      cyc(1'b0, 4'($urandom_range(0, 15)));
      chk("tog_bin_valid_lo", 32'(bus.bin_valid), 0);
      chk("tog_bin_held", 32'(bus.bin_out), k);
    end
    chk("tog_locked", 32'(bus.locked), 1);
    chk("tog_err_count", 32'(bus.err_count), 0);
    for (int n = 0; n < 400; n++) begin
      v = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 9);
      g = r < 6 ? b2g((m_ref + 1) % 16) : r < 8 ? b2g(m_ref) : 4'($urandom_range(0, 15));
      cyc(v, g);
    end
    for (int n = 0; n < 300; n++) cyc(1'b1, n % 2 ? 4'hF : 4'h0);
    chk("sat_err_count", 32'(bus.err_count), 255);
    cyc(1'b1, 4'h0);
    chk("sat_hold_err_count", 32'(bus.err_count), 255);
    chk("sat_step_err", 32'(bus.step_err), 1);
    do_reset();
    cyc(1'b1, 4'h0);
    cyc(1'b1, 4'hF);
    cyc(1'b1, 4'h0);
    cyc(1'b1, 4'hF);
    cyc(1'b1, 4'hE);
    cyc(1'b1, 4'hA);
    chk("pre_rst_locked", 32'(bus.locked), 1);
    chk("pre_rst_err_count", 32'(bus.err_count), 3);
    do_reset();
    cyc(1'b1, 4'h6);
    chk("post_rst_bin", 32'(bus.bin_out), 4);
    chk("post_rst_step_err", 32'(bus.step_err), 0);
    chk("post_rst_locked", 32'(bus.locked), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
